// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: R-type function codes, mul/div
// sequencer states and iteration count.
package ex_pkg;
    localparam int MD_ITER = 32;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B; the low two bits select the op.
    function automatic logic is_md(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction
endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide on operand magnitudes, one step per negedge.
// done is high during the last step; hi/lo are valid while done is high.
module md_unit
    import ex_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] opnd, raw_a;
    logic             neg_q, neg_r, div0;

    // op[0]=1 selects the unsigned variant, op[1]=1 selects divide
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // Shift-add step: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_next;
    assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {msum, acc[WIDTH-1:1]};

    // Restoring step: dividend bits shift out of acc low half, quotient bits shift in
    logic [WIDTH:0]   r_sh, rem_next;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] quo_next;
    assign r_sh     = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign diff     = {1'b0, r_sh} - {2'b0, opnd};
    assign rem_next = diff[WIDTH+1] ? r_sh : diff[WIDTH:0];
    assign quo_next = {acc[WIDTH-2:0], ~diff[WIDTH+1]};

    assign busy = (state != ST_IDLE);
    assign done = busy && (count == CW'(WIDTH-1));

    always_comb begin
        hi = '0;
        lo = '0;
        if (state == ST_MUL) begin
            {hi, lo} = neg_q ? -mul_next : mul_next;
        end else if (div0) begin
            hi = raw_a;
            lo = '1;
        end else begin
            hi = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
            lo = neg_q ? -quo_next : quo_next;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            acc   <= '0;
            rem   <= '0;
            opnd  <= '0;
            raw_a <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                state <= op[1] ? ST_DIV : ST_MUL;
                count <= '0;
                acc   <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                opnd  <= op[1] ? mag_b : mag_a;
                rem   <= '0;
                raw_a <= a;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                div0  <= op[1] && (b == '0);
            end
        end else begin
            count <= count + 1'b1;
            if (state == ST_MUL) begin
                acc <= mul_next;
            end else begin
                acc[WIDTH-1:0] <= quo_next;
                rem            <= rem_next;
            end
            if (done) state <= ST_IDLE;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle R-type ALU, HI/LO registers and an
// iterative mul/div that stalls upstream while it runs.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             E_valid,
    input  logic [WIDTH-1:0] E_busA,
    input  logic [WIDTH-1:0] E_busB,
    input  logic [5:0]       E_func,
    input  logic [15:0]      E_immd,
    input  logic [4:0]       E_Rd,
    output logic [WIDTH-1:0] M_ALUout,
    output logic [4:0]       M_Rd,
    output logic             M_RegWr,
    output logic             M_Ovf,
    output logic             Stall
);
    logic [WIDTH-1:0] hi, lo, md_hi, md_lo;
    logic             md_busy, md_done, md_start;

    assign md_start = E_valid && !md_busy && is_md(E_func);
    assign Stall    = md_busy;

    md_unit #(.WIDTH(WIDTH)) u_md (
        .clk  (Clk),
        .rst  (Rst),
        .start(md_start),
        .op   (E_func[1:0]),
        .a    (E_busA),
        .b    (E_busB),
        .busy (md_busy),
        .done (md_done),
        .hi   (md_hi),
        .lo   (md_lo)
    );

    logic [4:0]       shamt;
    logic [WIDTH-1:0] sum, dif, res;
    logic             wr, ovf;
    assign shamt = E_immd[10:6];
    assign sum   = E_busA + E_busB;
    assign dif   = E_busA - E_busB;

    always_comb begin
        res = '0;
        wr  = 1'b0;
        ovf = 1'b0;
        if (E_valid) begin
            wr = 1'b1;
            case (E_func)
                FN_SLL:  res = E_busB << shamt;
                FN_SRL:  res = E_busB >> shamt;
                FN_SRA:  res = $signed(E_busB) >>> shamt;
                FN_ADD: begin
                    res = sum;
                    ovf = (E_busA[WIDTH-1] == E_busB[WIDTH-1]) && (sum[WIDTH-1] != E_busA[WIDTH-1]);
                end
                FN_ADDU: res = sum;
                FN_SUB: begin
                    res = dif;
                    ovf = (E_busA[WIDTH-1] != E_busB[WIDTH-1]) && (dif[WIDTH-1] != E_busA[WIDTH-1]);
                end
                FN_SUBU: res = dif;
                FN_AND:  res = E_busA & E_busB;
                FN_OR:   res = E_busA | E_busB;
                FN_XOR:  res = E_busA ^ E_busB;
                FN_NOR:  res = ~(E_busA | E_busB);
                FN_SLT:  res = WIDTH'($signed(E_busA) < $signed(E_busB));
                FN_SLTU: res = WIDTH'(E_busA < E_busB);
                FN_MFHI: res = hi;
                FN_MFLO: res = lo;
                default: wr = 1'b0;  // MTHI/MTLO, mul/div issue and unknown codes
            endcase
            if (ovf) wr = 1'b0;
        end
    end

    always_ff @(negedge Clk) begin
        if (Rst) begin
            M_ALUout <= '0;
            M_Rd     <= '0;
            M_RegWr  <= 1'b0;
            M_Ovf    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            M_Rd <= E_Rd;
            if (md_busy) begin
                M_ALUout <= '0;
                M_RegWr  <= 1'b0;
                M_Ovf    <= 1'b0;
                if (md_done) begin
                    hi <= md_hi;
                    lo <= md_lo;
                end
            end else begin
                M_ALUout <= res;
                M_RegWr  <= wr;
                M_Ovf    <= ovf;
                if (E_valid && E_func == FN_MTHI) hi <= E_busA;
                if (E_valid && E_func == FN_MTLO) lo <= E_busA;
            end
        end
    end
endmodule
